// File: rtl/grid_rx_pkg.sv
// Shared types for the grid-update receiver: payload layout, FSM states and
// the GPIO packet width helper.
package grid_rx_pkg;

  localparam int unsigned GRID_COORD_W = 4;
  localparam int unsigned GRID_VALUE_W = 2;

  typedef struct packed {
    logic [GRID_COORD_W-1:0] x;
    logic [GRID_COORD_W-1:0] y;
    logic [GRID_VALUE_W-1:0] value;
  } grid_payload_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CHECK    = 2'd2,
    WAIT_LOW = 2'd3
  } rx_state_e;

  function automatic int unsigned pkt_width(input int unsigned coord_w,
                                            input int unsigned value_w,
                                            input int unsigned parity_en);
    return 2 * coord_w + value_w + parity_en;
  endfunction

endpackage

// File: rtl/grid_rx_fifo.sv
// Small synchronous FIFO; a push into a full FIFO succeeds when a pop frees
// the slot in the same cycle. Storage resets to zero so the head reads 0.
module grid_rx_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              full_c,
  output logic              empty_c,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign rd_data_c = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty_c;
  assign do_push   = push & (~full_c | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/grid_update_receiver.sv
// GPIO grid-update receiver: synchronise bus, detect strobe edge, settle,
// parity/duplicate filter, FIFO to the grid-memory writer, debug counters.
module grid_update_receiver
  import grid_rx_pkg::*;
#(
  parameter int unsigned COORD_W       = GRID_COORD_W,
  parameter int unsigned VALUE_W       = GRID_VALUE_W,
  parameter int unsigned PARITY_EN     = 1,
  parameter int unsigned DEDUP_EN      = 1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                                            CLOCK_50,
  input  logic                                            RESET_N,
  input  logic [pkt_width(COORD_W, VALUE_W, PARITY_EN)-1:0] DATA_IN,
  input  logic                                            ENABLE_IN,
  input  logic                                            WR_READY,
  output logic                                            WR_VALID,
  output logic [COORD_W-1:0]                              X_COORD,
  output logic [COORD_W-1:0]                              Y_COORD,
  output logic [VALUE_W-1:0]                              VALUE,
  output logic [CNT_W-1:0]                                PARITY_ERR_CNT,
  output logic [CNT_W-1:0]                                OVERFLOW_CNT,
  output logic [CNT_W-1:0]                                DUP_CNT
);

  localparam int unsigned PKT_W = pkt_width(COORD_W, VALUE_W, PARITY_EN);
  localparam int unsigned PAY_W = $bits(grid_payload_t);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0][PKT_W-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0]            en_sync_q, en_sync_d;
  logic                              en_prev_q, en_prev_d;
  logic                              edge_q, edge_d;
  logic                              en_sync;

  rx_state_e                         state_q, state_d;
  logic [SET_W-1:0]                  settle_q, settle_d;
  logic [PKT_W-1:0]                  pkt_q, pkt_d;
  grid_payload_t                     last_q, last_d;
  logic                              last_valid_q, last_valid_d;
  logic [CNT_W-1:0]                  par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]                  ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]                  dup_cnt_q, dup_cnt_d;

  grid_payload_t                     pkt_payload;
  grid_payload_t                     head;
  logic                              parity_bad, is_dup;
  logic                              fifo_push, fifo_pop, fifo_full, fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Synchroniser chains and registered rising-edge detect.
  assign en_sync = en_sync_q[SYNC_STAGES-1];

  always_comb begin
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], ENABLE_IN};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], DATA_IN};
    en_prev_d   = en_sync;
    edge_d      = en_sync & ~en_prev_q;
  end

  assign pkt_payload = grid_payload_t'(pkt_q[PKT_W-1 -: PAY_W]);
  assign parity_bad  = (PARITY_EN != 0) ? (^pkt_q) : 1'b0;
  assign is_dup      = (DEDUP_EN != 0) ? (last_valid_q && (pkt_payload == last_q)) : 1'b0;
  assign fifo_pop    = ~fifo_empty & WR_READY;

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    pkt_d        = pkt_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    par_cnt_d    = par_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    dup_cnt_d    = dup_cnt_q;
    fifo_push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_q) begin
          settle_d = SET_W'(SETTLE_CYCLES - 1);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          pkt_d   = data_sync_q[SYNC_STAGES-1];
          state_d = CHECK;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      CHECK: begin
        state_d = WAIT_LOW;
        // A pop in this cycle frees a slot, so full only drops when nothing drains.
        if (parity_bad) begin
          par_cnt_d = sat_inc(par_cnt_q);
        end else if (is_dup) begin
          dup_cnt_d = sat_inc(dup_cnt_q);
        end else if (fifo_full && !fifo_pop) begin
          ovf_cnt_d = sat_inc(ovf_cnt_q);
        end else begin
          fifo_push    = 1'b1;
          last_d       = pkt_payload;
          last_valid_d = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!en_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      data_sync_q  <= '0;
      en_sync_q    <= '0;
      en_prev_q    <= 1'b0;
      edge_q       <= 1'b0;
      state_q      <= IDLE;
      settle_q     <= '0;
      pkt_q        <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      par_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      dup_cnt_q    <= '0;
    end else begin
      data_sync_q  <= data_sync_d;
      en_sync_q    <= en_sync_d;
      en_prev_q    <= en_prev_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      settle_q     <= settle_d;
      pkt_q        <= pkt_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      par_cnt_q    <= par_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      dup_cnt_q    <= dup_cnt_d;
    end
  end

  grid_rx_fifo #(
    .DATA_W (PAY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .push      (fifo_push),
    .wr_data   (pkt_payload),
    .pop       (fifo_pop),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .rd_data_c (head)
  );

  assign WR_VALID       = ~fifo_empty;
  assign X_COORD        = head.x;
  assign Y_COORD        = head.y;
  assign VALUE          = head.value;
  assign PARITY_ERR_CNT = par_cnt_q;
  assign OVERFLOW_CNT   = ovf_cnt_q;
  assign DUP_CNT        = dup_cnt_q;

endmodule

// File: tb/tb_grid_update_receiver.sv
// Scoreboard bench for grid_update_receiver: stimulus pushes expected writes
// from a packet-level reference model, a monitor pops them on each handshake.
module tb_grid_update_receiver;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic [10:0] DATA_IN;
  logic        ENABLE_IN;
  logic        WR_READY;
  logic        WR_VALID;
  logic [3:0]  X_COORD;
  logic [3:0]  Y_COORD;
  logic [1:0]  VALUE;
  logic [7:0]  PARITY_ERR_CNT;
  logic [7:0]  OVERFLOW_CNT;
  logic [7:0]  DUP_CNT;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  int         m_par, m_dup, m_ovf;
  logic [9:0] m_last;
  logic       m_last_valid;

  always #5 CLOCK_50 = ~CLOCK_50;

  grid_update_receiver dut (
    .CLOCK_50       (CLOCK_50),
    .RESET_N        (RESET_N),
    .DATA_IN        (DATA_IN),
    .ENABLE_IN      (ENABLE_IN),
    .WR_READY       (WR_READY),
    .WR_VALID       (WR_VALID),
    .X_COORD        (X_COORD),
    .Y_COORD        (Y_COORD),
    .VALUE          (VALUE),
    .PARITY_ERR_CNT (PARITY_ERR_CNT),
    .OVERFLOW_CNT   (OVERFLOW_CNT),
    .DUP_CNT        (DUP_CNT)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] good(input logic [9:0] p);
    return {p, ^p};
  endfunction

  function automatic logic [10:0] bad(input logic [9:0] p);
    return {p, ~(^p)};
  endfunction

  function automatic int sat(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_par = 0;
    m_dup = 0;
    m_ovf = 0;
    m_last = '0;
    m_last_valid = 1'b0;
  endfunction

  // Packet-level reference: ready held for the whole packet window means the
  // FIFO has drained by the time the packet is judged.
  function automatic void model_pkt(input logic [10:0] d, input logic rdy);
    logic [9:0] p;
    p = d[10:1];
    if (($countones(d) % 2) == 1) m_par = sat(m_par);
    else if (m_last_valid && p == m_last) m_dup = sat(m_dup);
    else if (!rdy && exp_q.size() >= 4) m_ovf = sat(m_ovf);
    else begin
      exp_q.push_back(p);
      m_last = p;
      m_last_valid = 1'b1;
    end
  endfunction

  // Monitor: every handshake must match the oldest expected write.
  always @(negedge CLOCK_50) begin
    if (RESET_N === 1'b1 && WR_VALID === 1'b1 && WR_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual x=%0d y=%0d v=%0d required no write (t=%0t)",
                 X_COORD, Y_COORD, VALUE, $time);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("write_payload", int'({X_COORD, Y_COORD, VALUE}), int'(e));
      end
    end
  end

  task automatic check_state();
    chk("parity_err_cnt", int'(PARITY_ERR_CNT), m_par);
    chk("overflow_cnt", int'(OVERFLOW_CNT), m_ovf);
    chk("dup_cnt", int'(DUP_CNT), m_dup);
    if (WR_READY) chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic send_pkt(input logic [10:0] d, input int high);
    @(posedge CLOCK_50); #1;
    DATA_IN   = d;
    ENABLE_IN = 1'b1;
    model_pkt(d, WR_READY);
    repeat (high) @(posedge CLOCK_50);
    #1 ENABLE_IN = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1 check_state();
  endtask

  task automatic do_reset();
    #1 RESET_N = 1'b0;
    ENABLE_IN = 1'b0;
    DATA_IN   = '0;
    WR_READY  = 1'b1;
    model_clear();
    repeat (3) @(posedge CLOCK_50);
    #2 RESET_N = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int   n;
    logic seen;
    logic [10:0] d;
    logic [10:0] prev_d;

    RESET_N = 1'b0;
    do_reset();

    // Reset values.
    chk("reset_wr_valid", int'(WR_VALID), 0);
    chk("reset_x", int'(X_COORD), 0);
    chk("reset_y", int'(Y_COORD), 0);
    chk("reset_value", int'(VALUE), 0);
    check_state();

    // First packet: latency and single-cycle valid.
    @(posedge CLOCK_50); #1;
    DATA_IN   = 11'h1AD;
    ENABLE_IN = 1'b1;
    WR_READY  = 1'b1;
    model_pkt(11'h1AD, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLOCK_50);
      n++;
      @(negedge CLOCK_50);
      if (WR_VALID) seen = 1'b1;
    end
    chk("first_latency", seen ? n - 1 : -1, 7);
    chk("first_x", int'(X_COORD), 3);
    chk("first_y", int'(Y_COORD), 5);
    chk("first_value", int'(VALUE), 2);
    @(negedge CLOCK_50);
    chk("valid_one_cycle", int'(WR_VALID), 0);
    repeat (4) @(posedge CLOCK_50);
    #1 ENABLE_IN = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1 check_state();

    // Bad parity.
    send_pkt(11'h1AC, 10);
    chk("parity_one", int'(PARITY_ERR_CNT), 1);

    // Duplicate suppression from a fresh start.
    do_reset();
    send_pkt(11'h1AD, 10);
    send_pkt(11'h1AD, 10);
    chk("dup_one", int'(DUP_CNT), 1);
    send_pkt(11'h0F0, 10);
    send_pkt(11'h1AD, 10);

    // Overflow with the writer stalled, then ordered drain.
    WR_READY = 1'b0;
    for (int i = 0; i < 6; i++) send_pkt(good(10'(10'h100 + i * 7)), 10);
    chk("overflow_two", int'(OVERFLOW_CNT), 2);
    chk("stalled_valid", int'(WR_VALID), 1);
    WR_READY = 1'b1;
    repeat (8) @(posedge CLOCK_50);
    #1 chk("drained_all", exp_q.size(), 0);
    chk("drained_valid", int'(WR_VALID), 0);

    // Held strobe yields one packet.
    send_pkt(good(10'h2C3), 50);

    // Saturating parity counter.
    for (int i = 0; i < 300; i++) send_pkt(bad(10'($urandom)), 9);
    chk("parity_saturated", int'(PARITY_ERR_CNT), 255);

    // Reset while in SETTLE, strobe still high at release.
    @(posedge CLOCK_50); #1;
    d = good(10'h15A);
    DATA_IN   = d;
    ENABLE_IN = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    chk("midreset_wr_valid", int'(WR_VALID), 0);
    chk("midreset_parity", int'(PARITY_ERR_CNT), 0);
    chk("midreset_overflow", int'(OVERFLOW_CNT), 0);
    chk("midreset_dup", int'(DUP_CNT), 0);
    model_clear();
    repeat (2) @(posedge CLOCK_50);
    #2 RESET_N = 1'b1;
    model_pkt(d, 1'b1);
    repeat (20) @(posedge CLOCK_50);
    #1 ENABLE_IN = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1 check_state();

    // Randomised traffic with per-packet writer readiness.
    prev_d = d;
    for (int i = 0; i < 40; i++) begin
      WR_READY = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = prev_d;
        1:       d = bad(10'($urandom));
        default: d = good(10'($urandom));
      endcase
      send_pkt(d, $urandom_range(8, 14));
      prev_d = d;
    end
    WR_READY = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1 chk("final_drain", exp_q.size(), 0);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
